// File: rtl/mem_access_unit_if.sv
// Bundle of request, response and data-memory signals for mem_access_unit.
// The unit connects to the slave modport; the datapath/memory side connects to the master modport.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  resp_cause;

  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store bridge: lane-aligns stores, extracts and extends loads, flags misaligned
// accesses and memory timeouts, and returns exactly one response per accepted request.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'b10;

  // One-hot so req_ready, mem_en and resp_valid each come straight from a flop.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ISSUE = 3'b010,
    RESP  = 3'b100
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     size_q, size_d;
  logic           uns_q, uns_d;
  logic [2:0]     off_q, off_d;
  logic           mem_we_q, mem_we_d;
  logic [63:3]    mem_addr_q, mem_addr_d;
  logic [7:0]     mem_be_q, mem_be_d;
  logic [63:0]    mem_wdata_q, mem_wdata_d;
  logic [63:0]    resp_rdata_q, resp_rdata_d;
  logic           resp_err_q, resp_err_d;
  logic [1:0]     resp_cause_q, resp_cause_d;

  logic           misaligned;
  logic [7:0]     be_base;
  logic [7:0]     be_req;
  logic [63:0]    lane_mask;
  logic [63:0]    wdata_req;
  logic [63:0]    raw;
  logic           sx;
  logic [63:0]    load_ext;

  // Alignment and lane placement of the incoming request.
  always_comb begin
    misaligned = 1'b0;
    be_base    = 8'h01;
    unique case (bus.req_size)
      2'b00: begin misaligned = 1'b0;                 be_base = 8'h01; end
      2'b01: begin misaligned = bus.req_addr[0];      be_base = 8'h03; end
      2'b10: begin misaligned = |bus.req_addr[1:0];   be_base = 8'h0F; end
      default: begin misaligned = |bus.req_addr[2:0]; be_base = 8'hFF; end
    endcase
    be_req = be_base << bus.req_addr[2:0];
    for (int i = 0; i < 8; i++) lane_mask[8*i +: 8] = {8{be_req[i]}};
    wdata_req = (bus.req_wdata << {bus.req_addr[2:0], 3'b000}) & lane_mask;
  end

  // Right-justify the returned lanes, then extend from the access size.
  always_comb begin
    raw      = bus.mem_rdata >> {off_q, 3'b000};
    sx       = 1'b0;
    load_ext = raw;
    unique case (size_q)
      2'b00: begin sx = ~uns_q & raw[7];  load_ext = {{56{sx}}, raw[7:0]};  end
      2'b01: begin sx = ~uns_q & raw[15]; load_ext = {{48{sx}}, raw[15:0]}; end
      2'b10: begin sx = ~uns_q & raw[31]; load_ext = {{32{sx}}, raw[31:0]}; end
      default: load_ext = raw;
    endcase
  end

  // NOTE: every _d gets its hold value first, so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    resp_cause_d = resp_cause_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          size_d       = bus.req_size;
          uns_d        = bus.req_unsigned;
          off_d        = bus.req_addr[2:0];
          cnt_d        = '0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          resp_cause_d = CAUSE_NONE;
          if (misaligned) begin
            resp_err_d   = 1'b1;
            resp_cause_d = CAUSE_MISALIGN;
            state_d      = RESP;
          end else begin
            mem_we_d    = bus.req_write;
            mem_addr_d  = bus.req_addr[63:3];
            mem_be_d    = be_req;
            mem_wdata_d = wdata_req;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        // An ack on the final counted cycle still completes successfully.
        if (bus.mem_ack) begin
          if (!mem_we_q) resp_rdata_d = load_ext;
          mem_we_d = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_err_d   = 1'b1;
          resp_cause_d = CAUSE_TIMEOUT;
          mem_we_d     = 1'b0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      resp_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      resp_cause_q <= resp_cause_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_en     = (state_q == ISSUE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = {mem_addr_q, 3'b000};
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_cause = resp_cause_q;

endmodule
